// File: rtl/fibo_pkg.sv
// fibo_pkg: shared constants for the Fibonacci request scheduler.
//   - default widths of the term index (NW) and the term itself (DW)
//   - FSM state encodings (IDLE / RUN / CAPTURE / RESP)
//   - reset values for the response id and the completion counter
package fibo_pkg;

    localparam int NW_DEF = 8;
    localparam int DW_DEF = 8;

    // Two-bit state encoding shared by the scheduler and its debug port.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    localparam int          ID_RST       = 0;
    localparam logic [15:0] DONE_CNT_RST = 16'd0;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Ports:
//   req   in  NREQ  request vector
//   ptr   in  IDW   highest-priority requester for this cycle
//   grant out NREQ  one-hot grant (all zero when no request)
//   idx   out IDW   index of the granted requester
//   any   out 1     at least one request present
module rr_arbiter
    import fibo_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    // Scan ptr, ptr+1, ... (mod NREQ); the first set request wins.
    always_comb begin : scan
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/fibo_sched.sv
// fibo_sched: round-robin scheduler sharing one Fibonacci step core among
// NREQ requesters. Each accepted request N clears the core, advances it N
// times, captures F(N) mod 2^DW and returns it tagged with the requester id.
//
// Handshakes:
//   request : req_ready[g] is a one-hot, single-cycle accept strobe raised
//             combinationally in IDLE for the granted requester; a request is
//             consumed on the clock edge where req_valid[g] and req_ready[g]
//             are both high.
//   response: resp_valid rises and resp_data/resp_id are held stable until
//             the edge where resp_valid and resp_ready are both high; that
//             edge completes the transfer and resp_valid drops after it.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_n       per-requester valid and flattened term index
//   req_ready             one-hot accept strobe
//   resp_valid/ready/data/id   result channel
//   busy                  high whenever not IDLE
//   done_cnt              wrapping count of completed responses
//   core_clr/core_adv     core controls; core_out is the core's term
//   state                 current FSM state (debug)
module fibo_sched
    import fibo_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int NW   = NW_DEF,
    parameter int DW   = DW_DEF,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*NW-1:0] req_n,
    output logic [NREQ-1:0]    req_ready,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [DW-1:0]      resp_data,
    output logic [IDW-1:0]     resp_id,
    output logic               busy,
    output logic [15:0]        done_cnt,
    output logic               core_clr,
    output logic               core_adv,
    input  logic [DW-1:0]      core_out,
    output logic [1:0]         state
);

    logic [IDW-1:0]  rr_ptr;
    logic [NW-1:0]   cnt;
    logic [IDW-1:0]  id;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gidx;
    logic            gany;
    logic [NW-1:0]   sel_n;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    // Term index of the granted requester (one-hot mux).
    always_comb begin
        sel_n = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) sel_n = req_n[i*NW +: NW];
        end
    end

    assign req_ready = (state == ST_IDLE) ? grant : '0;
    assign busy      = (state != ST_IDLE);
    // The core is held in clear outside RUN, so it never idles un-cleared.
    assign core_clr  = (state != ST_RUN);
    assign core_adv  = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            cnt        <= '0;
            id         <= IDW'(ID_RST);
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= IDW'(ID_RST);
            done_cnt   <= DONE_CNT_RST;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gany) begin
                        cnt    <= sel_n;
                        id     <= gidx;
                        rr_ptr <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);
                        // N=0 skips RUN: the cleared core already shows F(0).
                        state  <= (sel_n != '0) ? ST_RUN : ST_CAPTURE;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt - NW'(1);
                    if (cnt == NW'(1)) state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // Core has taken exactly N advancing edges since clear.
                    resp_data  <= core_out;
                    resp_id    <= id;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        done_cnt   <= done_cnt + 16'd1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fibo_sched.sv
// tb_fibo_sched: directed bench for fibo_sched with a behavioural
// Fibonacci step core, a table of single requests, and hand-written
// sequences for contention, back-pressure and mid-run reset.
module tb_fibo_sched;

    localparam int NREQ = 2;
    localparam int NW   = 8;
    localparam int DW   = 8;
    localparam int IDW  = 2;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*NW-1:0] req_n;
    logic [NREQ-1:0]    req_ready;
    logic               resp_valid;
    logic               resp_ready;
    logic [DW-1:0]      resp_data;
    logic [IDW-1:0]     resp_id;
    logic               busy;
    logic [15:0]        done_cnt;
    logic               core_clr;
    logic               core_adv;
    logic [DW-1:0]      core_out;
    logic [1:0]         state;

    int errors = 0;
    int checks = 0;

    logic [IDW+DW-1:0] exp_q[$];

    typedef struct {
        int          id;
        int          n;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[8];

    fibo_sched #(
        .NREQ (NREQ),
        .NW   (NW),
        .DW   (DW),
        .IDW  (IDW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_n      (req_n),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy),
        .done_cnt   (done_cnt),
        .core_clr   (core_clr),
        .core_adv   (core_adv),
        .core_out   (core_out),
        .state      (state)
    );

    // ---------------- clock / core model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step core: keeps (F(k), F(k+1)); clear loads (0, 1).
    logic [DW-1:0] core_nxt;
    always @(posedge clk) begin
        if (core_clr) begin
            core_out <= '0;
            core_nxt <= 8'd1;
        end else if (core_adv) begin
            core_out <= core_nxt;
            core_nxt <= core_out + core_nxt;
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [7:0] fib_ref(input int n);
        logic [7:0] a, b, t;
        a = 8'd0;
        b = 8'd1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sb_compare(input string name);
        logic [IDW+DW-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got response id %0d data %0d expected no response", name, resp_id, resp_data);
        end else begin
            e = exp_q.pop_front();
            check({name, "_id"},   32'(resp_id),   32'(e[IDW+DW-1:DW]));
            check({name, "_data"}, 32'(resp_data), 32'(e[DW-1:0]));
        end
    endtask

    // One isolated request with resp_ready held high.
    task automatic do_req(input int id, input int n, input logic [7:0] exp_data);
        int   lat;
        bit   seen;
        logic [15:0] done_before;
        @(negedge clk);
        req_valid[id] = 1'b1;
        req_n[id*NW +: NW] = NW'(n);
        #1;
        check("grant", 32'(req_ready), 32'(1) << id);
        exp_q.push_back({IDW'(id), exp_data});
        @(negedge clk);
        req_valid[id] = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < n + 20) begin
            #1;
            if (resp_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check("latency", 32'(lat), 32'(n + 2));
        if (seen) begin
            sb_compare("resp");
            done_before = done_cnt;
            @(negedge clk);
            #1;
            check("valid_drop", 32'(resp_valid), 32'(0));
            check("done_inc", 32'(done_cnt), 32'(done_before + 16'd1));
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        vecs[0] = '{0, 10,  8'd55};
        vecs[1] = '{1, 0,   8'd0};
        vecs[2] = '{0, 14,  8'd121};
        vecs[3] = '{1, 13,  8'd233};
        vecs[4] = '{0, 1,   8'd1};
        vecs[5] = '{1, 255, fib_ref(255)};
        vecs[6] = '{0, 2,   8'd1};
        vecs[7] = '{1, 5,   8'd5};

        rst        = 1'b1;
        req_valid  = '0;
        req_n      = '0;
        resp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_state",      32'(state),      32'(0));
        check("rst_resp_valid", 32'(resp_valid), 32'(0));
        check("rst_resp_data",  32'(resp_data),  32'(0));
        check("rst_resp_id",    32'(resp_id),    32'(0));
        check("rst_req_ready",  32'(req_ready),  32'(0));
        check("rst_busy",       32'(busy),       32'(0));
        check("rst_done_cnt",   32'(done_cnt),   32'(0));
        check("rst_core_clr",   32'(core_clr),   32'(1));
        check("rst_core_adv",   32'(core_adv),   32'(0));
        rst = 1'b0;

        // Table of isolated requests (ends with rr_ptr back at 0)
        for (int i = 0; i < 8; i++) begin
            do_req(vecs[i].id, vecs[i].n, vecs[i].exp);
        end
        check("table_done_cnt", 32'(done_cnt), 32'(8));

        // Contention: both requesters hold valid; grants alternate
        begin
            int g_cnt, r_cnt, gid;
            bit drop;
            logic [15:0] done_before;
            g_cnt = 0;
            r_cnt = 0;
            drop  = 1'b0;
            done_before = done_cnt;
            @(negedge clk);
            req_n     = {8'd5, 8'd3};
            req_valid = 2'b11;
            for (int c = 0; c < 300 && r_cnt < 4; c++) begin
                if (c != 0) @(negedge clk);
                if (drop) begin
                    req_valid = '0;
                    drop = 1'b0;
                end
                #1;
                if (req_ready != '0) begin
                    gid = req_ready[1] ? 1 : 0;
                    check("t4_grant", 32'(gid), 32'(g_cnt % 2));
                    exp_q.push_back({IDW'(gid), (gid == 0) ? 8'd2 : 8'd5});
                    g_cnt++;
                    if (g_cnt == 4) drop = 1'b1;
                end
                if (resp_valid) begin
                    sb_compare("t4_resp");
                    r_cnt++;
                end
            end
            req_valid = '0;
            check("t4_resp_count", 32'(r_cnt), 32'(4));
            @(negedge clk);
            #1;
            check("t4_done_cnt", 32'(done_cnt), 32'(done_before + 16'd4));
            check("t4_no_extra_grant", 32'(g_cnt), 32'(4));
        end

        // Back-pressure: resp_ready low for 7 cycles after resp_valid rises
        begin
            int lat;
            resp_ready = 1'b0;
            @(negedge clk);
            req_valid[0] = 1'b1;
            req_n[7:0]   = 8'd10;
            #1;
            check("t5_grant", 32'(req_ready), 32'(1));
            exp_q.push_back({IDW'(0), 8'd55});
            @(negedge clk);
            req_valid[0] = 1'b0;
            req_valid[1] = 1'b1;
            req_n[15:8]  = 8'd3;
            lat = 1;
            #1;
            while (!resp_valid && lat < 40) begin
                @(negedge clk);
                #1;
                lat++;
            end
            check("t5_latency", 32'(lat), 32'(12));
            for (int c = 0; c < 7; c++) begin
                if (c != 0) begin
                    @(negedge clk);
                    #1;
                end
                check("t5_hold_valid", 32'(resp_valid), 32'(1));
                check("t5_hold_data",  32'(resp_data),  32'(55));
                check("t5_hold_id",    32'(resp_id),    32'(0));
                check("t5_hold_busy",  32'(busy),       32'(1));
                check("t5_no_grant",   32'(req_ready),  32'(0));
            end
            @(negedge clk);
            req_valid[1] = 1'b0;
            resp_ready   = 1'b1;
            #1;
            check("t5_still_valid", 32'(resp_valid), 32'(1));
            sb_compare("t5_resp");
            @(negedge clk);
            #1;
            check("t5_valid_drop", 32'(resp_valid), 32'(0));
            check("t5_idle_grant", 32'(req_ready),  32'(0));
        end

        // Reset in the 50th RUN cycle of an N=200 request
        begin
            bit saw;
            @(negedge clk);
            req_valid[0] = 1'b1;
            req_n[7:0]   = 8'd200;
            #1;
            check("t6_grant", 32'(req_ready), 32'(1));
            @(negedge clk);
            req_valid[0] = 1'b0;
            repeat (49) @(negedge clk);
            #1;
            check("t6_in_run", 32'(state), 32'(1));
            rst = 1'b1;
            @(negedge clk);
            #1;
            check("t6_state",      32'(state),      32'(0));
            check("t6_resp_valid", 32'(resp_valid), 32'(0));
            check("t6_core_clr",   32'(core_clr),   32'(1));
            check("t6_done_cnt",   32'(done_cnt),   32'(0));
            check("t6_busy",       32'(busy),       32'(0));
            rst = 1'b0;
            saw = 1'b0;
            repeat (260) begin
                @(negedge clk);
                #1;
                if (resp_valid) saw = 1'b1;
            end
            check("t6_no_resp", 32'(saw), 32'(0));
            do_req(0, 1, 8'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
